// File: rtl/gray_to_binary_serial_if.sv
// Word-level handshake bundle for the serial Gray-to-binary decoder: Gray word in, binary result out.
// master drives the Gray word and consumes the result; slave is the decoder.
interface gray_to_binary_serial_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_gray;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bin;
    logic             busy;
    logic             adj_err;

    modport master (
        output in_valid,
        output in_gray,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bin,
        input  busy,
        input  adj_err
    );

    modport slave (
        input  in_valid,
        input  in_gray,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bin,
        output busy,
        output adj_err
    );
endinterface

// File: rtl/gray_to_binary_serial.sv
// Serial Gray-to-binary decoder, MSB first, one bit per clock; adjacency checker under G2B_ADJ_CHECK_EN.
// Latency: WIDTH cycles from accept to out_valid; one word per WIDTH+2 cycles at best.
// Backpressure: holds result in DONE while out_ready is low; in_ready only in IDLE.
module gray_to_binary_serial #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    gray_to_binary_serial_if.slave  bus
);
    localparam int IDXW = $clog2(WIDTH);
    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] gray_sr;
    logic [WIDTH-1:0] bin_q;
    logic [IDXW-1:0]  idx;
    logic             acc;
    logic             next_bit;
    logic             accept;

    assign accept = bus.in_valid && (state == ST_IDLE);

    // acc carries the previously resolved (higher) binary bit; it starts at 0 so b[MSB] = g[MSB].
    assign next_bit = acc ^ gray_sr[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            gray_sr <= '0;
            bin_q   <= '0;
            idx     <= '0;
            acc     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        gray_sr <= bus.in_gray;
                        idx     <= IDX_MSB;
                        acc     <= 1'b0;
                        state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bin_q[idx] <= next_bit;
                    acc        <= next_bit;
                    gray_sr    <= {gray_sr[WIDTH-2:0], 1'b0};
                    if (idx == '0) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx - IDX_ONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.out_bin   = bin_q;

`ifdef G2B_ADJ_CHECK_EN
    localparam logic [WIDTH-1:0] WORD_ONE = WIDTH'(1);

    logic [WIDTH-1:0] hist;
    logic             hist_vld;
    logic [WIDTH-1:0] diff;
    logic             single_flip;
    logic             adj_q;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign diff        = bus.in_gray ^ hist;
    assign single_flip = (diff != '0) && ((diff & (diff - WORD_ONE)) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist     <= '0;
            hist_vld <= 1'b0;
            adj_q    <= 1'b0;
        end else if (accept) begin
            adj_q    <= hist_vld && !single_flip;
            hist     <= bus.in_gray;
            hist_vld <= 1'b1;
        end
    end

    assign bus.adj_err = adj_q;
`else
    assign bus.adj_err = 1'b0;
`endif

endmodule

// File: doc/gray_to_binary_serial.md
# gray_to_binary_serial

Sequential Gray-to-binary decoder, the receive-side counterpart of the combinational binary-to-Gray encoder in the code-converter set. Accepts one WIDTH-bit Gray word over a valid/ready handshake, resolves it serially MSB-first, one bit per clock (b[i] = b[i+1] ^ g[i]), then holds the binary result under a valid/ready output handshake. Intended for decoding Gray-coded counter and pointer values sampled from other logic. An optional adjacency checker flags successive input words that differ in more than one bit.

## Interface
- WIDTH, 4, Gray/binary word width; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_gray holds a word to convert.
- in_gray  input  WIDTH  Gray-coded input word.
- in_ready  output  1  block can accept a word; high only in IDLE.
- out_valid  output  1  out_bin holds a completed result.
- out_ready  input  1  consumer accepts out_bin.
- out_bin  output  WIDTH  binary result; stable while out_valid is high.
- busy  output  1  high in CONV or DONE.
- adj_err  output  1  adjacency error for the word in out_bin; qualified by out_valid.

## Operation
- Reset is asynchronous and active-high. On reset: state is IDLE, in_ready=1, out_valid=0, busy=0, out_bin=0, adj_err=0, bit index=0, history register and history-valid flag cleared.
- The FSM has three states:
  - IDLE: in_ready=1. When in_valid&&in_ready at an edge, capture in_gray into the shift register, set idx=WIDTH-1, and go to CONV.
  - CONV: each edge computes bit idx. out_bin[WIDTH-1]=g[WIDTH-1]; for lower bits, out_bin[idx]=out_bin[idx+1]^g[idx]. Then idx decrements. After the edge that computes bit 0, go to DONE.
  - DONE: out_valid=1. When out_valid&&out_ready at an edge, return to IDLE.
- Inputs are ignored outside IDLE. in_gray is sampled only on the accept edge and may change afterwards.
- An output transfer and a new accept never occur on the same edge. Peak throughput is one word per WIDTH+2 cycles.
- If out_ready is held low, the block stays in DONE indefinitely with out_bin and adj_err stable.
- out_bin is not cleared on a new accept. Its bits are overwritten MSB-first during CONV, so intermediate values are not meaningful.
- An all-zeros or all-ones input requires no special handling.

## Timing
- Accept on edge k. Bit WIDTH-1 is written on edge k+1 and bit 0 on edge k+WIDTH.
- out_valid goes high after edge k+WIDTH, giving a latency of WIDTH cycles.
- With out_ready high, the output transfers on edge k+WIDTH+1, and in_ready returns high after that edge.
- busy rises after edge k and falls after the transfer edge.
- If rst is asserted mid-CONV or in DONE, the block immediately returns to the reset state. The in-flight word is discarded and no out_valid pulse is produced.

## Configuration
- G2B_ADJ_CHECK_EN defined:
  - On each accept, compare in_gray with the previously accepted word.
  - adj_err is set to 1 if the popcount of the XOR is not equal to 1 and history is valid. A repeated identical word therefore also flags an error.
  - adj_err is then held through DONE.
  - The history register is updated on accept and history-valid is set.
  - The first word after reset always gives adj_err=0.
- G2B_ADJ_CHECK_EN undefined: the history logic is absent, the adj_err port still exists and is tied to 0, and conversion behaviour is unchanged.

## Test plan
- Reset values: assert rst, release, check idle defaults. Required: in_ready=1, out_valid=0, busy=0, out_bin=0, adj_err=0.
- WIDTH=4, sweep with back-pressure off: apply in_gray=0110, then 1101, 1000, 0000, with out_ready=1. Required out_bin: 0100, 1001, 1111, 0000. out_valid must rise exactly 4 cycles after each accept.
- Back-pressure: with out_ready=0, apply in_gray=1000. Required:
  - out_bin=1111 held for 10 cycles.
  - in_ready stays 0 and a new in_valid is ignored.
  - Raising out_ready completes the transfer in 1 cycle, then in_ready=1.
- Reset mid-CONV: accept 0110, assert rst 2 cycles later. Required: out_valid never asserts, all outputs return to reset values, and the next word 0001 decodes to 0001.
- Adjacency check, with G2B_ADJ_CHECK_EN defined: apply words 0110, 0111, 1000, 1000. Required adj_err: 0 (first word), 0, 1, 1. With the macro undefined, adj_err is 0 for all four words.
- WIDTH=8: apply in_gray=8'hC0, then 8'h01. Required out_bin: 8'h80, 8'h01. Latency is 8 cycles.
